ff_driver_bank: RTL
===================

Name: ff_driver_bank

Overview:
- Multi-channel, parametrised force-format pin driver for the ASIC tester.
- Each channel independently applies one of several drive formats to its vector bit, relative to programmable leading and trailing edge positions within a tester cycle.
- Vectors arrive through a valid/ready stream into a one-deep pending buffer. They are applied on cycle boundaries, and a buffer underflow is flagged.
- Sits between the vector sequencer and the DUT pin outputs.

Parameters:
- NCH, 8, number of channels (1..32).
- CW, 8, width of the cycle counter and of the timing inputs.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- EN  in  1  run enable; low = idle/prime
- CYCLE_LENGTH  in  CW  ticks per tester cycle (0 treated as 1)
- LEADING_EDGE  in  CW  tick on which the leading event fires
- TRAILING_EDGE  in  CW  tick on which the trailing event fires
- VEC_D  in  NCH  drive data, one bit per channel
- VEC_FF  in  3*NCH  format code per channel; channel i uses bits [3i+2:3i]
- VEC_VALID  in  1  vector offered
- VEC_READY  out  1  vector accepted when VALID && READY
- Q  out  NCH  driven pin values
- CYCLE_START  out  1  one-tick pulse when the active vector changes at a boundary
- UNDERFLOW  out  1  sticky: a boundary occurred with the pending buffer empty
- CNT  out  CW  current tick, 1..CYCLE_LENGTH

Behaviour:
- Interface: reset RST, synchronous, active-high; clock CLK.
- Reset values: Q=0, CNT=1, CYCLE_START=0, UNDERFLOW=0, pending buffer empty, active D=0, active FF=0.
- Timing shadow registers (cl, le, te) load from CYCLE_LENGTH, LEADING_EDGE and TRAILING_EDGE:
  - while EN=0, every clock;
  - while EN=1, at each boundary.
  - Mid-cycle changes to these inputs are ignored.
- Counter:
  - EN=0: CNT held at 1.
  - EN=1: CNT increments each clock.
  - When CNT >= max(cl,1), the tick is a boundary and CNT returns to 1 next clock.
- Pending buffer:
  - VEC_READY = pending empty OR a transfer out of pending occurs this clock.
  - An accept and a transfer on the same clock keep the pending buffer full, holding the new vector.
- Transfer rules:
  - EN=0: pending moves to active on the clock after acceptance (priming). CYCLE_START stays 0.
  - EN=1, boundary, pending full: pending moves to active. CYCLE_START=1 on the following clock, aligned with CNT=1.
  - EN=1, boundary, pending empty: active is retained (vector repeats), UNDERFLOW is set, CYCLE_START=0.
  - UNDERFLOW clears only on RST.
- Q register, per channel, from active d and f, evaluated on each EN=1 clock. The result appears on Q one clock after CNT shows the tick.
  - f=0 NRZ: Q<=d at CNT=1.
  - f=1 DNRZ_L: Q<=d at CNT=le; held across cycles otherwise.
  - f=2 RZ: Q<=d at CNT=le; Q<=0 at CNT=te.
  - f=3 R1: Q<=d at CNT=le; Q<=1 at CNT=te.
  - f=4 SBC: Q<=~d at CNT=1; Q<=d at CNT=le; Q<=~d at CNT=te.
  - f=5..7 OFF: Q<=0 every clock.
- Event priority (le > te > CNT=1) when positions coincide:
  - SBC with le=1: d.
  - RZ/R1 with le=te: d.
- An edge position of 0 or > cl never fires.
- EN=0: Q is held.
- EN falling mid-cycle: cycle aborts, CNT=1 next clock, Q held.
- RST mid-cycle: full reset next clock; pending and active vectors are discarded.

Test Plan:
- NCH=2, cl=8, le=3, te=6, ch0 RZ d=1, ch1 R1 d=0, one vector primed, EN=1 -> Q[0]=1 on the clock after CNT=3, 0 after CNT=6. Q[1]=0 after CNT=3, 1 after CNT=6. Vector repeats and UNDERFLOW=1 after the first boundary.
- Stream 4 vectors with VALID held high, cl=4 -> VEC_READY low while pending is full and one transfer per boundary. CYCLE_START pulses 3 times, aligned with CNT=1. UNDERFLOW stays 0 until the stream stops.
- SBC d=1, le=2, te=3, cl=4 -> Q sequence per cycle 0,1,0,0 (lagging CNT by one clock). le=te=2 -> Q=1 from tick 2 to the next boundary.
- DNRZ_L with d alternating 1,0,1 per cycle, le=2 -> Q changes only after CNT=2 and holds across the boundary. le=0 -> Q never changes.
- Change LEADING_EDGE from 3 to 5 at CNT=4 (cl=8) -> the current cycle still uses 3, the next cycle uses 5.
- Assert RST at CNT=5 with pending full -> next clock Q=0, CNT=1, VEC_READY=1, UNDERFLOW=0. Drop EN mid-cycle -> CNT=1 and Q held.

Source files
------------

// File: rtl/ff_driver_bank.sv
// Multi-channel force-format pin driver: each channel shapes its vector bit on
// programmable leading/trailing edges, fed through a one-deep pending vector buffer.
module ff_driver_bank #(
    parameter int NCH = 8,
    parameter int CW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [CW-1:0]    CYCLE_LENGTH,
    input  logic [CW-1:0]    LEADING_EDGE,
    input  logic [CW-1:0]    TRAILING_EDGE,
    input  logic [NCH-1:0]   VEC_D,
    input  logic [3*NCH-1:0] VEC_FF,
    input  logic             VEC_VALID,
    output logic             VEC_READY,
    output logic [NCH-1:0]   Q,
    output logic             CYCLE_START,
    output logic             UNDERFLOW,
    output logic [CW-1:0]    CNT
);
    localparam logic [CW-1:0] TICK_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] TICK_ZERO  = {CW{1'b0}};
    localparam logic [2:0]    FMT_NRZ    = 3'd0;
    localparam logic [2:0]    FMT_DNRZ_L = 3'd1;
    localparam logic [2:0]    FMT_RZ     = 3'd2;
    localparam logic [2:0]    FMT_R1     = 3'd3;
    localparam logic [2:0]    FMT_SBC    = 3'd4;

    logic [CW-1:0]    cl_r, le_r, te_r, cnt_r;
    logic             pend_full_r;
    logic [NCH-1:0]   pend_d_r, act_d_r;
    logic [3*NCH-1:0] pend_f_r, act_f_r;
    logic [NCH-1:0]   q_r, q_next_s;
    logic             cs_r, uf_r;

    logic [CW-1:0]    cl_eff_s;
    logic             boundary_s, transfer_s, accept_s, reload_s;
    logic             at_start_s, at_lead_s, at_trail_s;

    // Leading event wins over trailing, which wins over the cycle-start event.
    function automatic logic drive_bit(
        input logic [2:0] fmt,
        input logic       d,
        input logic       cur,
        input logic       at_start,
        input logic       at_lead,
        input logic       at_trail
    );
        logic r;
        r = cur;
        case (fmt)
            FMT_NRZ:    r = at_start ? d : cur;
            FMT_DNRZ_L: r = at_lead ? d : cur;
            FMT_RZ:     r = at_lead ? d : (at_trail ? 1'b0 : cur);
            FMT_R1:     r = at_lead ? d : (at_trail ? 1'b1 : cur);
            FMT_SBC:    r = at_lead ? d : ((at_trail || at_start) ? ~d : cur);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // Cycle position decode and vector handshake.
    always_comb begin
        cl_eff_s   = (cl_r == TICK_ZERO) ? TICK_ONE : cl_r;
        boundary_s = EN && (cnt_r >= cl_eff_s);
        transfer_s = pend_full_r && (!EN || boundary_s);
        accept_s   = VEC_VALID && (!pend_full_r || transfer_s);
        reload_s   = !EN || boundary_s;
        at_start_s = (cnt_r == TICK_ONE);
        // Edges at 0 or beyond the cycle length can never match the counter.
        at_lead_s  = (le_r != TICK_ZERO) && (le_r <= cl_eff_s) && (cnt_r == le_r);
        at_trail_s = (te_r != TICK_ZERO) && (te_r <= cl_eff_s) && (cnt_r == te_r);
    end

    // Next pin values; pins freeze whenever the driver is idle.
    always_comb begin
        q_next_s = q_r;
        if (EN) begin
            for (int i = 0; i < NCH; i++) begin
                q_next_s[i] = drive_bit(act_f_r[3*i +: 3], act_d_r[i], q_r[i],
                                        at_start_s, at_lead_s, at_trail_s);
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Timing shadows track the inputs while idle and refresh only at boundaries when running.
    always_ff @(posedge CLK) begin
        if (RST || reload_s) begin
            cl_r <= CYCLE_LENGTH;
            le_r <= LEADING_EDGE;
            te_r <= TRAILING_EDGE;
        end else begin
            cl_r <= cl_r;
            le_r <= le_r;
            te_r <= te_r;
        end
    end

    // Tick counter, 1..cycle length.
    always_ff @(posedge CLK) begin
        if (RST || reload_s) begin
            cnt_r <= TICK_ONE;
        end else begin
            cnt_r <= cnt_r + TICK_ONE;
        end
    end

    // Pending buffer: a same-clock accept and transfer leaves it full with the new vector.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_full_r <= 1'b0;
            pend_d_r    <= {NCH{1'b0}};
            pend_f_r    <= {(3*NCH){1'b0}};
        end else if (accept_s) begin
            pend_full_r <= 1'b1;
            pend_d_r    <= VEC_D;
            pend_f_r    <= VEC_FF;
        end else if (transfer_s) begin
            pend_full_r <= 1'b0;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Active vector; retained (repeated) when a boundary finds the buffer empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            act_d_r <= {NCH{1'b0}};
            act_f_r <= {(3*NCH){1'b0}};
        end else if (transfer_s) begin
            act_d_r <= pend_d_r;
            act_f_r <= pend_f_r;
        end else begin
            act_d_r <= act_d_r;
            act_f_r <= act_f_r;
        end
    end

    // Registered pins and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r  <= {NCH{1'b0}};
            cs_r <= 1'b0;
            uf_r <= 1'b0;
        end else begin
            q_r  <= q_next_s;
            cs_r <= boundary_s && pend_full_r;
            uf_r <= uf_r || (boundary_s && !pend_full_r);
        end
    end

    assign VEC_READY   = !pend_full_r || transfer_s;
    assign Q           = q_r;
    assign CYCLE_START = cs_r;
    assign UNDERFLOW   = uf_r;
    assign CNT         = cnt_r;

endmodule
